// File: rtl/twos_to_signmag_serial.sv
// twos_to_signmag_serial
//   Bit-serial two's-complement to sign-magnitude decoder. A word is accepted in
//   IDLE, walked LSB first through SHIFT using the copy-until-first-1-then-invert
//   rule (no carry chain), and presented in DONE until the consumer takes it.
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready input handshake; in_ready = IDLE and not in reset
//   in_data           two's-complement input word
//   out_valid         result valid (DONE state)
//   out_ready         consumer accepts the result
//   out_sign          1 = input was negative
//   out_mag           unsigned magnitude of the input
//   out_ovf           input was the most negative value
module twos_to_signmag_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_ovf
);

  localparam int unsigned     CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST     = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  shr;
  logic [WIDTH-1:0]  magsr;
  logic              sgn;
  logic              ovf;
  logic              seen_one;

  logic              accept;
  logic              last_bit;
  logic              obit;

  // Handshake flags derived straight from state.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last_bit  = (cnt == LAST);

  // Bits below and including the first 1 pass through; above it a negative word is inverted.
  assign obit = (sgn && seen_one) ? ~shr[0] : shr[0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Serial datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      shr      <= '0;
      magsr    <= '0;
      sgn      <= 1'b0;
      ovf      <= 1'b0;
      seen_one <= 1'b0;
      out_sign <= 1'b0;
      out_mag  <= '0;
      out_ovf  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            shr      <= in_data;
            sgn      <= in_data[WIDTH-1];
            ovf      <= (in_data == MOST_NEG);
            cnt      <= '0;
            seen_one <= 1'b0;
          end
        end
        SHIFT: begin
          seen_one <= seen_one | shr[0];
          shr      <= shr >> 1;
          magsr    <= {obit, magsr[WIDTH-1:1]};
          if (last_bit) begin
            // Counter parks at zero so it never exceeds WIDTH-1.
            cnt      <= '0;
            out_mag  <= {obit, magsr[WIDTH-1:1]};
            out_sign <= sgn;
            out_ovf  <= ovf;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Directed bench for twos_to_signmag_serial (WIDTH=8). Inputs driven just after
// posedge or at negedge; outputs sampled at negedge.
module tb_twos_to_signmag_serial;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sign;
  logic [7:0] out_mag;
  logic       out_ovf;

  int tests;
  int fails;

  twos_to_signmag_serial #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mag   (out_mag),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one word, check latency, result, then complete the output handshake.
  task automatic decode(input string tag, input logic [7:0] d,
                        input logic es, input logic [7:0] em, input logic eo);
    @(negedge clk);
    chk({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk({tag, " not valid at E+7"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " valid at E+8"}, 32'(out_valid), 32'd1);
    chk({tag, " sign"}, 32'(out_sign), 32'(es));
    chk({tag, " mag"}, 32'(out_mag), 32'(em));
    chk({tag, " ovf"}, 32'(out_ovf), 32'(eo));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " valid drop"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_sign", 32'(out_sign), 32'd0);
    chk("rst out_mag", 32'(out_mag), 32'd0);
    chk("rst out_ovf", 32'(out_ovf), 32'd0);
    rst = 1'b0;

    // Arithmetic vectors
    decode("pos5",  8'h05, 1'b0, 8'h05, 1'b0);
    decode("neg5",  8'hFB, 1'b1, 8'h05, 1'b0);
    decode("neg1",  8'hFF, 1'b1, 8'h01, 1'b0);
    decode("zero",  8'h00, 1'b0, 8'h00, 1'b0);
    decode("mneg",  8'h80, 1'b1, 8'h80, 1'b1);
    decode("pmax",  8'h7F, 1'b0, 8'h7F, 1'b0);
    decode("neg86", 8'hAA, 1'b1, 8'h56, 1'b0);

    // Output registers hold last result in IDLE
    @(negedge clk);
    chk("idle hold mag", 32'(out_mag), 32'h56);

    // Backpressure: 0x9C (-100) held in DONE for 3 cycles
    chk("bp in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h9C;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp valid", 32'(out_valid), 32'd1);
      chk("bp in_ready low", 32'(in_ready), 32'd0);
      chk("bp sign", 32'(out_sign), 32'd1);
      chk("bp mag", 32'(out_mag), 32'h64);
      @(posedge clk);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp release valid", 32'(out_valid), 32'd0);
    chk("bp release in_ready", 32'(in_ready), 32'd1);

    // in_valid held high with new data during SHIFT is ignored
    in_valid = 1'b1;
    in_data  = 8'h7E;
    @(posedge clk);
    #1 in_data = 8'h33;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("hold in_ready shift", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("hold valid", 32'(out_valid), 32'd1);
    chk("hold mag first", 32'(out_mag), 32'h7E);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold idle in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("hold second valid", 32'(out_valid), 32'd1);
    chk("hold second mag", 32'(out_mag), 32'h33);
    chk("hold second sign", 32'(out_sign), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in cycle 3 of SHIFT aborts the word
    in_valid = 1'b1;
    in_data  = 8'h85;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd0);
    chk("abort out_mag", 32'(out_mag), 32'd0);
    chk("abort out_sign", 32'(out_sign), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("abort no result", 32'(out_valid), 32'd0);

    decode("negtwo", 8'hFE, 1'b1, 8'h02, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
